// File: rtl/tmr_scrub_pkg.sv
// Shared encodings for the TMR scrub reader: injection target select and
// err_loc bit positions.
package tmr_scrub_pkg;

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_C    = 2'd2,
    SEL_NONE = 2'd3
  } inj_sel_e;

  localparam int unsigned LOC_A = 0;
  localparam int unsigned LOC_B = 1;
  localparam int unsigned LOC_C = 2;

endpackage

// File: rtl/tmr_maj3.sv
// Bitwise 2-of-3 majority vote across three equal-width words.
module tmr_maj3 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = (a & b) | (b & c) | (a & c);
  end

endmodule

// File: rtl/tmr_scrub_reader.sv
// Triple-redundant register with majority-voted read, optional scrubbing,
// fault injection, and mismatch status (pulse, sticky flag, counter, location).
module tmr_scrub_reader
  import tmr_scrub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             c,
  input  logic             rst_b,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic             scrub_en,
  input  logic             inj_en,
  input  logic [1:0]       inj_sel,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             err,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       err_loc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] copy_a, copy_b, copy_c;
  logic [WIDTH-1:0] a_nxt, b_nxt, c_nxt;
  logic             mm, mm_prev, evt;
  logic [2:0]       loc_now;
  inj_sel_e         sel;

  assign sel = inj_sel_e'(inj_sel);

  tmr_maj3 #(.WIDTH(WIDTH)) u_maj (
    .a (copy_a),
    .b (copy_b),
    .c (copy_c),
    .y (q)
  );

  always_comb begin
    mm  = (copy_a != copy_b) | (copy_b != copy_c);
    evt = mm & ~mm_prev;
    loc_now        = '0;
    loc_now[LOC_A] = (copy_a != q);
    loc_now[LOC_B] = (copy_b != q);
    loc_now[LOC_C] = (copy_c != q);
  end

  // Priority: write, then injection, then scrub-on-mismatch, else hold.
  always_comb begin
    a_nxt = copy_a;
    b_nxt = copy_b;
    c_nxt = copy_c;
    if (we) begin
      a_nxt = d;
      b_nxt = d;
      c_nxt = d;
    end else if (inj_en) begin
      case (sel)
        SEL_A:   a_nxt = copy_a ^ inj_mask;
        SEL_B:   b_nxt = copy_b ^ inj_mask;
        SEL_C:   c_nxt = copy_c ^ inj_mask;
        default: ;
      endcase
    end else if (mm && scrub_en) begin
      a_nxt = q;
      b_nxt = q;
      c_nxt = q;
    end
  end

  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      copy_a <= '0;
      copy_b <= '0;
      copy_c <= '0;
    end else begin
      copy_a <= a_nxt;
      copy_b <= b_nxt;
      copy_c <= c_nxt;
    end
  end

  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      err     <= 1'b0;
      mm_prev <= 1'b0;
    end else begin
      err     <= mm;
      mm_prev <= mm;
    end
  end

  // Set wins over clear so a persisting mismatch is never hidden.
  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      err_flag <= 1'b0;
    end else if (mm) begin
      err_flag <= 1'b1;
    end else if (clr) begin
      err_flag <= 1'b0;
    end
  end

  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= evt ? CNT_W'(1) : '0;
    end else if (evt && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      err_loc <= '0;
    end else if (mm) begin
      err_loc <= loc_now;
    end else if (clr) begin
      err_loc <= '0;
    end
  end

endmodule

// File: tb/tb_tmr_scrub_reader.sv
// Directed, table-driven bench for tmr_scrub_reader with hand-computed
// expectations plus saturation, clear-with-event and async-reset sequences.
module tb_tmr_scrub_reader;

  logic       c;
  logic       rst_b;
  logic       we;
  logic [7:0] d;
  logic       scrub_en;
  logic       inj_en;
  logic [1:0] inj_sel;
  logic [7:0] inj_mask;
  logic       clr;
  logic [7:0] q;
  logic       err;
  logic       err_flag;
  logic [7:0] err_cnt;
  logic [2:0] err_loc;

  int n_chk;
  int n_fail;

  tmr_scrub_reader #(.WIDTH(8), .CNT_W(8)) dut (
    .c        (c),
    .rst_b    (rst_b),
    .we       (we),
    .d        (d),
    .scrub_en (scrub_en),
    .inj_en   (inj_en),
    .inj_sel  (inj_sel),
    .inj_mask (inj_mask),
    .clr      (clr),
    .q        (q),
    .err      (err),
    .err_flag (err_flag),
    .err_cnt  (err_cnt),
    .err_loc  (err_loc)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       scrub;
    logic       inj;
    logic [1:0] sel;
    logic [7:0] mask;
    logic       clr;
    logic [7:0] q;
    logic       err;
    logic       flag;
    logic [7:0] cnt;
    logic [2:0] loc;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] dd, input logic s, input logic i,
                       input logic [1:0] sl, input logic [7:0] m, input logic cl);
    we = w; d = dd; scrub_en = s; inj_en = i; inj_sel = sl; inj_mask = m; clr = cl;
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic ee,
                         input logic ef, input logic [7:0] ec, input logic [2:0] el);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".err"}, 32'(err), 32'(ee));
    chk({tag, ".err_flag"}, 32'(err_flag), 32'(ef));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    chk({tag, ".err_loc"}, 32'(err_loc), 32'(el));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //          we  d      scr  inj  sel    mask   clr  q      err  flag cnt    loc
    vecs[0]  = '{1, 8'hA5, 0,   0,   2'd0, 8'h00, 0,   8'hA5, 0,   0,   8'd0, 3'b000};
    vecs[1]  = '{0, 8'h00, 0,   0,   2'd0, 8'h00, 0,   8'hA5, 0,   0,   8'd0, 3'b000};
    vecs[2]  = '{0, 8'h00, 1,   1,   2'd1, 8'h0F, 0,   8'hA5, 0,   0,   8'd0, 3'b000};
    vecs[3]  = '{0, 8'h00, 1,   0,   2'd0, 8'h00, 0,   8'hA5, 1,   1,   8'd1, 3'b010};
    vecs[4]  = '{0, 8'h00, 1,   0,   2'd0, 8'h00, 0,   8'hA5, 0,   1,   8'd1, 3'b010};
    vecs[5]  = '{0, 8'h00, 0,   0,   2'd0, 8'h00, 1,   8'hA5, 0,   0,   8'd0, 3'b000};
    vecs[6]  = '{0, 8'h00, 0,   1,   2'd1, 8'h0F, 0,   8'hA5, 0,   0,   8'd0, 3'b000};
    vecs[7]  = '{0, 8'h00, 0,   0,   2'd0, 8'h00, 0,   8'hA5, 1,   1,   8'd1, 3'b010};
    vecs[8]  = '{0, 8'h00, 0,   0,   2'd0, 8'h00, 0,   8'hA5, 1,   1,   8'd1, 3'b010};
    vecs[9]  = '{0, 8'h00, 0,   0,   2'd0, 8'h00, 1,   8'hA5, 1,   1,   8'd0, 3'b010};
    vecs[10] = '{1, 8'h5A, 0,   0,   2'd0, 8'h00, 0,   8'h5A, 1,   1,   8'd0, 3'b010};
    vecs[11] = '{0, 8'h00, 0,   0,   2'd0, 8'h00, 0,   8'h5A, 0,   1,   8'd0, 3'b010};
    vecs[12] = '{1, 8'h3C, 0,   1,   2'd0, 8'hFF, 0,   8'h3C, 0,   1,   8'd0, 3'b010};
    vecs[13] = '{0, 8'h00, 0,   0,   2'd0, 8'h00, 0,   8'h3C, 0,   1,   8'd0, 3'b010};
    vecs[14] = '{0, 8'h00, 1,   1,   2'd3, 8'hFF, 0,   8'h3C, 0,   1,   8'd0, 3'b010};
    vecs[15] = '{0, 8'h00, 1,   0,   2'd0, 8'h00, 0,   8'h3C, 0,   1,   8'd0, 3'b010};
    vecs[16] = '{0, 8'h00, 1,   1,   2'd2, 8'h81, 0,   8'h3C, 0,   1,   8'd0, 3'b010};
    vecs[17] = '{0, 8'h00, 1,   0,   2'd0, 8'h00, 0,   8'h3C, 1,   1,   8'd1, 3'b100};
    vecs[18] = '{0, 8'h00, 0,   1,   2'd0, 8'hC3, 0,   8'h3C, 0,   1,   8'd1, 3'b100};
    vecs[19] = '{0, 8'h00, 1,   0,   2'd0, 8'h00, 1,   8'h3C, 1,   1,   8'd1, 3'b001};

    drive(0, 8'h00, 0, 0, 2'd0, 8'h00, 0);
    rst_b = 1'b0;
    #12;
    chk_all("reset", 8'h00, 0, 0, 8'd0, 3'b000);
    #5 rst_b = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].we, vecs[i].d, vecs[i].scrub, vecs[i].inj, vecs[i].sel, vecs[i].mask, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].err, vecs[i].flag, vecs[i].cnt, vecs[i].loc);
    end

    // Row 19 scrubbed copy A and cleared the count to 1 in the same edge.
    drive(0, 8'h00, 1, 0, 2'd0, 8'h00, 1);
    step();
    chk_all("postclr", 8'h3C, 0, 0, 8'd0, 3'b000);

    // Saturation: 255 isolated events, then one more.
    for (int i = 0; i < 255; i++) begin
      drive(0, 8'h00, 1, 1, 2'd1, 8'h01, 0);
      step();
      drive(0, 8'h00, 1, 0, 2'd0, 8'h00, 0);
      step();
    end
    chk("sat.cnt255", 32'(err_cnt), 32'd255);
    chk("sat.flag", 32'(err_flag), 32'd1);
    drive(0, 8'h00, 1, 1, 2'd1, 8'h01, 0);
    step();
    drive(0, 8'h00, 1, 0, 2'd0, 8'h00, 0);
    step();
    chk("sat.hold", 32'(err_cnt), 32'd255);
    chk("sat.q", 32'(q), 32'h3C);

    // clr coinciding with a new event leaves a count of one.
    drive(0, 8'h00, 1, 1, 2'd2, 8'h10, 0);
    step();
    drive(0, 8'h00, 1, 0, 2'd0, 8'h00, 1);
    step();
    chk("clrevt.cnt", 32'(err_cnt), 32'd1);
    chk("clrevt.flag", 32'(err_flag), 32'd1);
    chk("clrevt.loc", 32'(err_loc), 32'b100);
    drive(0, 8'h00, 1, 0, 2'd0, 8'h00, 0);
    step();
    chk("clrevt.err0", 32'(err), 32'd0);

    // Async reset mid-cycle while a scrub is pending.
    drive(0, 8'h00, 0, 1, 2'd0, 8'hF0, 0);
    step();
    drive(0, 8'h00, 0, 0, 2'd0, 8'h00, 0);
    step();
    chk("prerst.err", 32'(err), 32'd1);
    scrub_en = 1'b1;
    #2;
    rst_b = 1'b0;
    #1;
    chk_all("asyncrst", 8'h00, 0, 0, 8'd0, 3'b000);
    @(posedge c);
    #3;
    rst_b = 1'b1;
    step();
    chk_all("postrst1", 8'h00, 0, 0, 8'd0, 3'b000);
    step();
    chk_all("postrst2", 8'h00, 0, 0, 8'd0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
